fp_result_buffer: RTL and testbench
===================================

FP_RESULT_BUFFER -- requirements
Module: fp_result_buffer

Interface
REQ-001 The block SHALL have one parameter: DEPTH, default 4, number of FIFO entries (power of two, 2 to 16).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  upstream multiplier result valid.
REQ-005 in_ready  output  1  buffer can accept an entry this cycle.
REQ-006 in_result  input  32  IEEE-754 single-precision product.
REQ-007 in_exception  input  1  multiplier Exception flag.
REQ-008 in_overflow  input  1  multiplier Overflow flag.
REQ-009 in_underflow  input  1  multiplier Underflow flag.
REQ-010 out_valid  output  1  head entry available.
REQ-011 out_ready  input  1  downstream consumes head this cycle.
REQ-012 out_data  output  32  head entry product.
REQ-013 out_flags  output  3  head entry flags {exception, overflow, underflow}.
REQ-014 fifo_count  output  5  current occupancy, 0..DEPTH.
REQ-015 sticky_flags  output  3  OR of flags of all entries accepted since the last reset or clear.
REQ-016 clear_sticky  input  1  synchronous clear of sticky flags and event counters.

Function
REQ-017 Each entry SHALL store 35 bits: {in_exception, in_overflow, in_underflow, in_result}.
REQ-018 Push SHALL occur when in_valid and in_ready are both high; pop SHALL occur when out_valid and out_ready are both high.
REQ-019 in_ready SHALL be high exactly when fifo_count < DEPTH, including cycles where a pop also occurs; a full buffer never accepts.
REQ-020 out_valid SHALL be high exactly when fifo_count != 0.
REQ-021 The head SHALL be first-word-fall-through from registered storage, with no combinational in-to-out bypass; minimum latency is 1 cycle from push to out_valid.
REQ-022 When out_valid is low, out_data and out_flags SHALL be driven to zero.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH, and entries SHALL emerge in push order.
REQ-024 A simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-025 in_valid asserted while in_ready is low SHALL have no effect; upstream holds its data.
REQ-026 On each push, sticky_flags SHALL OR in the pushed flags.
REQ-027 On clear_sticky, sticky_flags SHALL load the flags of a simultaneous push, or zero if there is no push.
REQ-028 clear_sticky SHALL NOT affect FIFO contents, pointers or fifo_count.

Reset
REQ-029 While rst is high, pointers, fifo_count, sticky_flags and counters SHALL be zero, with in_ready=1, out_valid=0, out_data=0 and out_flags=0.
REQ-030 Reset asserted mid-operation SHALL discard all stored entries immediately, without waiting for a clock edge.
REQ-031 Storage array contents need not be reset; they are unobservable while the buffer is empty.

Configuration
REQ-032 The macro FP_RESULT_BUFFER_EVENT_COUNT_EN SHALL, when defined, add outputs exc_count, ovf_count and unf_count (16 bits each), one per flag.
REQ-033 With the macro defined, each counter SHALL increment on a push carrying its flag, saturate at 16'hFFFF, and reset to zero.
REQ-034 With the macro defined, clear_sticky SHALL set each counter to 1 if a simultaneous push carries its flag, else to 0.
REQ-035 Without the macro, the counter ports and logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-036 Reset, then push 32'h3F800000 with flags 0 and out_ready=0 -> next cycle out_valid=1, out_data=32'h3F800000, fifo_count=1.
REQ-037 With DEPTH=4 and out_ready=0, push 5 values -> in_ready=0 after the 4th push, 5th not accepted, fifo_count=4; then drain -> 4 values in order.
REQ-038 With the buffer full, hold in_valid=1 and out_ready=1 -> pop without push in that cycle (fifo_count 4->3), push resumes next cycle.
REQ-039 Push an entry with overflow=1, then in a later cycle assert clear_sticky together with a push of underflow=1 -> sticky_flags=3'b001; with the macro, ovf_count=0 and unf_count=1.
REQ-040 Push 3 entries, then assert rst asynchronously between clock edges -> out_valid=0, fifo_count=0 and out_data=0 immediately.
REQ-041 With the macro, push 70000 entries with exception=1 -> exc_count=16'hFFFF, no wrap.

Source files
------------

// File: rtl/fp_result_buffer.sv
// Result FIFO for the FP multiplier: first-word-fall-through head, sticky flag summary.
// Optional per-flag event counters are enabled by defining FP_RESULT_BUFFER_EVENT_COUNT_EN.
module fp_result_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_result,
  input  logic        in_exception,
  input  logic        in_overflow,
  input  logic        in_underflow,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [2:0]  out_flags,
  output logic [4:0]  fifo_count,
  output logic [2:0]  sticky_flags,
  input  logic        clear_sticky
`ifdef FP_RESULT_BUFFER_EVENT_COUNT_EN
  ,
  output logic [15:0] exc_count,
  output logic [15:0] ovf_count,
  output logic [15:0] unf_count
`endif
);

  localparam int unsigned PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int unsigned EW = 35;
  localparam int unsigned CW = 16;

  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [2:0]    in_flags;
  logic          push;
  logic          pop;

  assign in_flags  = {in_exception, in_overflow, in_underflow};
  assign in_ready  = (fifo_count < 5'(DEPTH));
  assign out_valid = (fifo_count != 5'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head is read straight from storage; zeroed while empty so stale entries never leak.
  assign head      = mem[rd_ptr];
  assign out_data  = out_valid ? head[31:0]  : 32'd0;
  assign out_flags = out_valid ? head[34:32] : 3'd0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_flags, in_result};
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= 5'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 5'd1;
        2'b01:   fifo_count <= fifo_count - 5'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_flags <= 3'd0;
    end else if (clear_sticky) begin
      sticky_flags <= push ? in_flags : 3'd0;
    end else if (push) begin
      sticky_flags <= sticky_flags | in_flags;
    end
  end

`ifdef FP_RESULT_BUFFER_EVENT_COUNT_EN
  // Index matches in_flags bit position: 2=exception, 1=overflow, 0=underflow.
  logic [CW-1:0] ev_cnt [3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) ev_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (clear_sticky) begin
          ev_cnt[i] <= (push && in_flags[i]) ? CW'(1) : CW'(0);
        end else if (push && in_flags[i] && (ev_cnt[i] != {CW{1'b1}})) begin
          ev_cnt[i] <= ev_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign exc_count = ev_cnt[2];
  assign ovf_count = ev_cnt[1];
  assign unf_count = ev_cnt[0];
`endif

endmodule

// File: tb/tb_fp_result_buffer.sv
// Self-checking bench for fp_result_buffer: queue-based reference model with per-cycle
// comparison, directed literal scenarios, and randomized traffic.
module tb_fp_result_buffer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_result = 32'd0;
  logic        in_exception = 1'b0;
  logic        in_overflow = 1'b0;
  logic        in_underflow = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [2:0]  out_flags;
  logic [4:0]  fifo_count;
  logic [2:0]  sticky_flags;
  logic        clear_sticky = 1'b0;
`ifdef FP_RESULT_BUFFER_EVENT_COUNT_EN
  logic [15:0] exc_count, ovf_count, unf_count;
`endif

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  fp_result_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_exception(in_exception), .in_overflow(in_overflow), .in_underflow(in_underflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_flags(out_flags),
    .fifo_count(fifo_count), .sticky_flags(sticky_flags), .clear_sticky(clear_sticky)
`ifdef FP_RESULT_BUFFER_EVENT_COUNT_EN
    , .exc_count(exc_count), .ovf_count(ovf_count), .unf_count(unf_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: entry queue, sticky OR and saturating per-flag counters.
  logic [34:0] mq[$];
  logic [2:0]  m_sticky = 3'd0;
  int          m_cnt[3] = '{0, 0, 0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_sticky = 3'd0;
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    end else begin
      bit do_push, do_pop;
      logic [2:0] f;
      f = {in_exception, in_overflow, in_underflow};
      do_push = in_valid && (mq.size() < DEPTH);
      do_pop  = out_ready && (mq.size() != 0);
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back({f, in_result});
      if (clear_sticky) m_sticky = do_push ? f : 3'd0;
      else if (do_push) m_sticky = m_sticky | f;
      for (int i = 0; i < 3; i++) begin
        if (clear_sticky) m_cnt[i] = (do_push && f[i]) ? 1 : 0;
        else if (do_push && f[i] && m_cnt[i] < 65535) m_cnt[i] = m_cnt[i] + 1;
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of every output against the model, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [34:0] h;
      bit v;
      v = (mq.size() != 0);
      h = v ? mq[0] : 35'd0;
      check("cmp_out_valid", 64'(out_valid), 64'(v));
      check("cmp_in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
      check("cmp_count", 64'(fifo_count), 64'(mq.size()));
      check("cmp_data", 64'(out_data), 64'(h[31:0]));
      check("cmp_flags", 64'(out_flags), 64'(h[34:32]));
      check("cmp_sticky", 64'(sticky_flags), 64'(m_sticky));
`ifdef FP_RESULT_BUFFER_EVENT_COUNT_EN
      check("cmp_exc_cnt", 64'(exc_count), 64'(m_cnt[2]));
      check("cmp_ovf_cnt", 64'(ovf_count), 64'(m_cnt[1]));
      check("cmp_unf_cnt", 64'(unf_count), 64'(m_cnt[0]));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; clear_sticky = 1'b0;
    {in_exception, in_overflow, in_underflow} = 3'b000;
    step();
    rst = 1'b0;
  endtask

  task automatic drive(input bit v, input logic [31:0] d, input logic [2:0] f);
    in_valid = v;
    in_result = d;
    {in_exception, in_overflow, in_underflow} = f;
  endtask

  initial begin
    chk_en = 1'b1;
    // Reset values while rst is held.
    #2;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_count", 64'(fifo_count), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_sticky", 64'(sticky_flags), 64'd0);
    do_reset();

    // Single push, one-cycle latency.
    drive(1'b1, 32'h3F800000, 3'b000);
    check("lat_before", 64'(out_valid), 64'd0);
    step();
    drive(1'b0, 32'h0, 3'b000);
    check("lat_valid", 64'(out_valid), 64'd1);
    check("lat_data", 64'(out_data), 64'h3F800000);
    check("lat_count", 64'(fifo_count), 64'd1);

    // Fill to DEPTH, then a rejected fifth push.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hA000_0000 + 32'(i), 3'(i));
      step();
    end
    check("full_ready", 64'(in_ready), 64'd0);
    check("full_count", 64'(fifo_count), 64'd4);
    drive(1'b1, 32'hA000_0004, 3'b111);
    step();
    check("full_hold_count", 64'(fifo_count), 64'd4);
    check("full_head", 64'(out_data), 64'hA000_0000);
    // Full with out_ready: pop only, push resumes next cycle.
    out_ready = 1'b1;
    step();
    check("full_pop_count", 64'(fifo_count), 64'd3);
    check("full_pop_head", 64'(out_data), 64'hA000_0001);
    step();
    drive(1'b0, 32'h0, 3'b000);
    check("resume_count", 64'(fifo_count), 64'd3);
    for (int i = 2; i <= 4; i++) begin
      check("drain_data", 64'(out_data), 64'hA000_0000 + 64'(i));
      step();
    end
    check("drain_empty", 64'(out_valid), 64'd0);
    check("drain_zero", 64'(out_data), 64'd0);
    out_ready = 1'b0;

    // Sticky flags and clear with simultaneous push.
    do_reset();
    drive(1'b1, 32'h7F800000, 3'b010);
    step();
    drive(1'b0, 32'h0, 3'b000);
    check("sticky_ovf", 64'(sticky_flags), 64'b010);
    step();
    drive(1'b1, 32'h00000001, 3'b001);
    clear_sticky = 1'b1;
    step();
    clear_sticky = 1'b0;
    drive(1'b0, 32'h0, 3'b000);
    check("sticky_clear", 64'(sticky_flags), 64'b001);
    check("sticky_fifo", 64'(fifo_count), 64'd2);
`ifdef FP_RESULT_BUFFER_EVENT_COUNT_EN
    check("clr_ovf_cnt", 64'(ovf_count), 64'd0);
    check("clr_unf_cnt", 64'(unf_count), 64'd1);
`endif

    // Asynchronous reset between edges drops stored entries at once.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hC0DE_0000 + 32'(i), 3'b100);
      step();
    end
    drive(1'b0, 32'h0, 3'b000);
    check("pre_arst_count", 64'(fifo_count), 64'd3);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_count", 64'(fifo_count), 64'd0);
    check("arst_data", 64'(out_data), 64'd0);
    step();
    rst = 1'b0;

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      logic [2:0] f;
      f = ($urandom_range(99) < 40) ? 3'($urandom) : 3'b000;
      drive($urandom_range(99) < 65, $urandom, f);
      out_ready = ($urandom_range(99) < 50);
      clear_sticky = ($urandom_range(99) < 4);
      rst = ($urandom_range(999) < 4);
      step();
    end
    rst = 1'b0;
    clear_sticky = 1'b0;
    drive(1'b0, 32'h0, 3'b000);

`ifdef FP_RESULT_BUFFER_EVENT_COUNT_EN
    // Exception counter saturates rather than wrapping.
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 32'h7FC00000, 3'b100);
    for (int c = 0; c < 70000; c++) step();
    drive(1'b0, 32'h0, 3'b000);
    check("sat_exc_cnt", 64'(exc_count), 64'hFFFF);
    check("sat_ovf_cnt", 64'(ovf_count), 64'd0);
`endif

    step();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
